// File: rtl/seq_shift_add_mult32.sv
// Iterative radix-2 unsigned shift-and-add multiplier, 32x32 -> 64.
// Each RUN cycle adds the multiplicand into P[63:32] through one CLA32, then shifts P right.

module cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_cbit;
    logic [8:0]  w_cgrp;

    assign w_g       = i_a & i_b;
    assign w_p       = i_a ^ i_b;
    assign w_cgrp[0] = i_cin;

    // 4-bit lookahead groups; group carries chain through group generate/propagate
    for (genvar k = 0; k < 8; k++) begin : g_grp
        logic [3:0] w_gg;
        logic [3:0] w_pp;
        logic       w_c0;
        logic       w_ggen;
        logic       w_gprop;

        assign w_gg = w_g[4*k +: 4];
        assign w_pp = w_p[4*k +: 4];
        assign w_c0 = w_cgrp[k];

        assign w_cbit[4*k]   = w_c0;
        assign w_cbit[4*k+1] = w_gg[0] | (w_pp[0] & w_c0);
        assign w_cbit[4*k+2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_c0);
        assign w_cbit[4*k+3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                             | (w_pp[2] & w_pp[1] & w_pp[0] & w_c0);

        assign w_ggen  = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                       | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
        assign w_gprop = &w_pp;

        assign w_cgrp[k+1] = w_ggen | (w_gprop & w_c0);
    end

    assign o_sum  = w_p ^ w_cbit;
    assign o_cout = w_cgrp[8];
endmodule

module seq_shift_add_mult32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [2*WIDTH-1:0]  r_p;
    logic [WIDTH-1:0]    r_mcand;
    logic [CW-1:0]       r_cnt;
    logic                r_out_valid;
    logic                r_busy;

    logic [WIDTH-1:0]    w_add_b;
    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;

    assign w_add_b = r_p[0] ? r_mcand : '0;

    cla32 u_cla (
        .i_a    (r_p[2*WIDTH-1:WIDTH]),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_p     <= {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // carry-out lands in P[63] so the full product is kept
                    r_p   <= {w_cout, w_sum, r_p[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_p;
endmodule

// File: tb/tb_seq_shift_add_mult32.sv
// Directed + random bench for seq_shift_add_mult32: latency, handshakes, reset abort, products.

module tb_seq_shift_add_mult32;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_shift_add_mult32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; counts edges until out_valid rises.
    task automatic wait_done(input string tag, input logic [63:0] exp);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_product"}, product, exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [63:0] exp);
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(tag, exp);
        if (out_ready) tick();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        tick();
        chk("rst_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_product",   product,        64'd0);

        run_op("3x5", 32'd3, 32'd5, 64'd15);
        chk("idle_after_3x5", 64'(in_ready), 64'd1);
        run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("zero",  32'h0, 32'h1234_5678, 64'h0);
        run_op("one",   32'h1, 32'h89AB_CDEF, 64'h0000_0000_89AB_CDEF);

        // Backpressure in DONE: result must hold, in_valid pulses must not be accepted.
        out_ready = 1'b0;
        run_op("bp", 32'h1000_0001, 32'h10, 64'h0000_0001_0000_0010);
        held = product;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = 32'hDEAD_0000 + 32'(i);
            b        = 32'h0000_BEEF;
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_product",   product,        held);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
        end

        // Release together with a pending request: accepted one cycle later.
        a         = 32'h0001_0000;
        b         = 32'h0001_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rel_in_ready",  64'(in_ready),  64'd1);
        chk("rel_busy",      64'(busy),      64'd0);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("rel_accept_busy", 64'(busy), 64'd1);
        wait_done("rel", 64'h0000_0001_0000_0000);
        tick();

        // Abort mid-RUN with reset.
        a        = 32'hABCD_1234;
        b        = 32'h5678_9ABC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy",      64'(busy),      64'd0);
        chk("abort_product",   product,        64'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);

        run_op("7x9", 32'd7, 32'd9, 64'd63);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("rand", ra, rb, {32'h0, ra} * {32'h0, rb});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
